// File: rtl/serial_bit_feeder_if.sv
// Word handshake into the serial bit feeder.
// Producer drives din/din_valid; feeder answers with din_ready.
interface serial_bit_feeder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-in, serial-out feeder for the zero-run detector input.
// One-word holding buffer lets consecutive words stream gaplessly.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  serial_bit_feeder_if.slave in_if,
  output logic              x,
  output logic              x_valid,
  output logic              busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             ready;
  logic             accept;
  logic             last;
  logic             load;
  logic [WIDTH-1:0] sreg_shifted;

  // Ready is gated by reset so nothing is offered before release.
  assign ready  = reset & ~hold_full_q;
  assign accept = in_if.din_valid & ready;
  assign last   = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign load   = (state_q == IDLE) || last;

  assign in_if.din_ready = ready;

  assign sreg_shifted = MSB_FIRST
    ? {sreg_q[WIDTH-2:0], 1'b0}
    : {1'b0, sreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    unique case (1'b1)
      load && hold_full_q: begin
        state_d     = SHIFT;
        cnt_d       = '0;
        sreg_d      = hold_q;
        hold_full_d = 1'b0;
      end
      // A word offered on the last bit goes straight into sreg.
      load && !hold_full_q && accept: begin
        state_d = SHIFT;
        cnt_d   = '0;
        sreg_d  = in_if.din;
      end
      load && !hold_full_q && !accept: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        cnt_d  = cnt_q + 1'b1;
        sreg_d = sreg_shifted;
        if (accept) begin
          hold_d      = in_if.din;
          hold_full_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    x       = IDLE_BIT;
    x_valid = 1'b0;
    busy    = hold_full_q;
    if (state_q == SHIFT) begin
      x       = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
      x_valid = 1'b1;
      busy    = 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: one MSB-first and one
// LSB-first instance driven from hand-computed bit patterns.
module tb_serial_bit_feeder;

  logic clk;
  logic reset;

  logic a_x, a_xv, a_busy;
  logic b_x, b_xv, b_busy;

  int n_tests;
  int n_fail;

  serial_bit_feeder_if #(.WIDTH(8)) a_if ();
  serial_bit_feeder_if #(.WIDTH(8)) b_if ();

  serial_bit_feeder #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)
  ) dut_a (
    .clk    (clk),
    .reset  (reset),
    .in_if  (a_if),
    .x      (a_x),
    .x_valid(a_xv),
    .busy   (a_busy)
  );

  serial_bit_feeder #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)
  ) dut_b (
    .clk    (clk),
    .reset  (reset),
    .in_if  (b_if),
    .x      (b_x),
    .x_valid(b_xv),
    .busy   (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got,
                       input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] pat;
  logic [15:0] rdy;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    a_if.din = '0; a_if.din_valid = 1'b0;
    b_if.din = '0; b_if.din_valid = 1'b0;

    // Reset held for three cycles
    repeat (3) step();
    check("rst_x",     a_x, 1'b1);
    check("rst_xv",    a_xv, 1'b0);
    check("rst_busy",  a_busy, 1'b0);
    check("rst_ready", a_if.din_ready, 1'b0);
    check("rst_b_x",   b_x, 1'b1);
    reset = 1'b1;
    #1;
    check("rel_ready", a_if.din_ready, 1'b1);

    // Single word 0x0F, MSB first
    a_if.din = 8'h0F; a_if.din_valid = 1'b1;
    step();
    a_if.din_valid = 1'b0;
    pat = 16'h0F00;
    for (int i = 0; i < 8; i++) begin
      check("single_x",  a_x, pat[15]);
      check("single_xv", a_xv, 1'b1);
      pat = pat << 1;
      step();
    end
    check("single_end_xv", a_xv, 1'b0);
    check("single_end_x",  a_x, 1'b1);
    check("single_end_busy", a_busy, 1'b0);

    // Back-to-back 0xA5, 0x00
    a_if.din = 8'hA5; a_if.din_valid = 1'b1;
    step();
    a_if.din = 8'h00;
    pat = 16'hA500;
    rdy = 16'b1000_0000_1111_1111;
    for (int i = 0; i < 16; i++) begin
      check("b2b_x",     a_x, pat[15]);
      check("b2b_xv",    a_xv, 1'b1);
      check("b2b_busy",  a_busy, 1'b1);
      check("b2b_ready", a_if.din_ready, rdy[15]);
      pat = pat << 1;
      rdy = rdy << 1;
      step();
      if (i == 0) a_if.din_valid = 1'b0;
    end
    check("b2b_end_xv", a_xv, 1'b0);
    check("b2b_end_x",  a_x, 1'b1);

    // LSB-first 0x01 on the second instance
    b_if.din = 8'h01; b_if.din_valid = 1'b1;
    step();
    b_if.din_valid = 1'b0;
    pat = 16'h8000;
    for (int i = 0; i < 8; i++) begin
      check("lsb_x",  b_x, pat[15]);
      check("lsb_xv", b_xv, 1'b1);
      pat = pat << 1;
      step();
    end
    check("lsb_end_xv", b_xv, 1'b0);
    check("lsb_end_x",  b_x, 1'b1);

    // Reset mid-word with a second word held
    a_if.din = 8'hF0; a_if.din_valid = 1'b1;
    step();
    a_if.din = 8'h3C;
    step();
    a_if.din_valid = 1'b0;
    check("mid_held_ready", a_if.din_ready, 1'b0);
    step();
    step();
    check("mid_bit3_x", a_x, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_x",     a_x, 1'b1);
    check("mid_rst_xv",    a_xv, 1'b0);
    check("mid_rst_busy",  a_busy, 1'b0);
    check("mid_rst_ready", a_if.din_ready, 1'b0);
    step();
    reset = 1'b1;
    #1;
    check("mid_rel_ready", a_if.din_ready, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step();
      check("mid_after_xv", a_xv, 1'b0);
      check("mid_after_x",  a_x, 1'b1);
    end

    // 0xFF offered exactly on the last bit of 0x00
    a_if.din = 8'h00; a_if.din_valid = 1'b1;
    step();
    a_if.din_valid = 1'b0;
    pat = 16'h00FF;
    for (int i = 0; i < 16; i++) begin
      check("last_x",     a_x, pat[15]);
      check("last_xv",    a_xv, 1'b1);
      check("last_ready", a_if.din_ready, 1'b1);
      pat = pat << 1;
      if (i == 7) begin
        a_if.din = 8'hFF; a_if.din_valid = 1'b1;
      end
      step();
      a_if.din_valid = 1'b0;
    end
    check("last_end_xv", a_xv, 1'b0);
    check("last_end_x",  a_x, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
